attack_sequencer: RTL and testbench

- Sits directly downstream of the combinational attack decoder.
- Turns its level-type attack request (attack_active, anim_ID) into a timed attack with three phases, advanced by the per-frame tick: STARTUP, ACTIVE and RECOVERY.
- Drives the hitbox enable, the latched animation ID and the frame index to the hit-detection and sprite/animation stages.
- Aborts the attack on hit stun.

---
 rtl/attack_sequencer.sv | 139 +++++++++++++
 tb/tb_attack_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_sequencer.sv
// Times a decoded attack request through STARTUP/ACTIVE/RECOVERY phases on frame ticks.
// Define ATK_BUFFER_EN to add a one-deep re-press buffer that chains attacks out of RECOVERY.
module attack_sequencer #(
   parameter int STARTUP_FRAMES  = 3,
   parameter int ACTIVE_FRAMES   = 4,
   parameter int RECOVERY_FRAMES = 6,
   parameter int FRAME_W         = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               attack_active,
   input  logic [3:0]         anim_ID_in,
   input  logic               hit_stun_active,
   output logic               atk_busy,
   output logic [1:0]         phase,
   output logic               hitbox_en,
   output logic [3:0]         anim_ID_out,
   output logic [FRAME_W-1:0] anim_frame,
   output logic               atk_done
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STARTUP  = 2'd1,
      ACTIVE   = 2'd2,
      RECOVERY = 2'd3
   } state_e;

   state_e             state_q;
   logic               req_q;
   logic [3:0]         anim_id_q;
   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_d;
   logic [FRAME_W-1:0] cnt_q;
   logic [FRAME_W-1:0] last_cnt;
   logic               done_q;
   logic               press;
   logic               start;
   logic               phase_end;
`ifdef ATK_BUFFER_EN
   logic               buf_q;
   logic [3:0]         buf_id_q;
   logic               buf_set;
`endif

   always_comb begin
      last_cnt = FRAME_W'(STARTUP_FRAMES - 1);
      case (state_q)
         ACTIVE:   last_cnt = FRAME_W'(ACTIVE_FRAMES - 1);
         RECOVERY: last_cnt = FRAME_W'(RECOVERY_FRAMES - 1);
         default:  last_cnt = FRAME_W'(STARTUP_FRAMES - 1);
      endcase
   end

   // Only a fresh rising edge counts, so a held button yields a single attack.
   assign press     = attack_active & ~req_q;
   assign start     = press & ~hit_stun_active;
   assign phase_end = frame_tick & (cnt_q == last_cnt);
   assign frame_d   = (&frame_q) ? frame_q : frame_q + FRAME_W'(1);
`ifdef ATK_BUFFER_EN
   assign buf_set   = (state_q == RECOVERY) & press & ~buf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         anim_id_q <= '0;
         frame_q   <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
`ifdef ATK_BUFFER_EN
         buf_q     <= 1'b0;
         buf_id_q  <= '0;
`endif
      end else begin
         req_q  <= attack_active;
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (start) begin
               state_q   <= STARTUP;
               anim_id_q <= anim_ID_in;
               cnt_q     <= '0;
               frame_q   <= '0;
            end
         end else if (hit_stun_active) begin
            // Stun wins over any tick or phase change in the same cycle.
            state_q   <= IDLE;
            anim_id_q <= '0;
            frame_q   <= '0;
            cnt_q     <= '0;
`ifdef ATK_BUFFER_EN
            buf_q     <= 1'b0;
`endif
         end else begin
`ifdef ATK_BUFFER_EN
            if (buf_set) begin
               buf_q    <= 1'b1;
               buf_id_q <= anim_ID_in;
            end
`endif
            if (frame_tick) begin
               frame_q <= frame_d;
               cnt_q   <= phase_end ? '0 : cnt_q + FRAME_W'(1);
               if (phase_end) begin
                  case (state_q)
                     STARTUP: state_q <= ACTIVE;
                     ACTIVE:  state_q <= RECOVERY;
                     default: begin
                        done_q <= 1'b1;
`ifdef ATK_BUFFER_EN
                        if (buf_q | buf_set) begin
                           state_q   <= STARTUP;
                           anim_id_q <= buf_q ? buf_id_q : anim_ID_in;
                           frame_q   <= '0;
                           buf_q     <= 1'b0;
                        end else begin
                           state_q <= IDLE;
                        end
`else
                        state_q <= IDLE;
`endif
                     end
                  endcase
               end
            end
         end
      end
   end

   assign atk_busy    = (state_q != IDLE);
   assign phase       = state_q;
   assign hitbox_en   = (state_q == ACTIVE) & ~hit_stun_active;
   assign anim_ID_out = anim_id_q;
   assign anim_frame  = frame_q;
   assign atk_done    = done_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Bench for attack_sequencer: tick-count model checked every cycle plus directed literal checks.
module tb_attack_sequencer;

   localparam int S     = 3;
   localparam int A     = 4;
   localparam int R     = 6;
   localparam int FW    = 5;
   localparam int TOTAL = S + A + R;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_tick = 1'b0;
   logic          attack_active = 1'b0;
   logic [3:0]    anim_ID_in = 4'd0;
   logic          hit_stun_active = 1'b0;
   logic          atk_busy;
   logic [1:0]    phase;
   logic          hitbox_en;
   logic [3:0]    anim_ID_out;
   logic [FW-1:0] anim_frame;
   logic          atk_done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int hit_cnt = 0;
   bit tick_en = 1'b0;

   // Model: an attack is just "busy + number of ticks since start".
   logic          m_busy = 1'b0;
   int            m_t = 0;
   logic [3:0]    m_id = 4'd0;
   logic [FW-1:0] m_frame = '0;
   logic          m_done = 1'b0;
   logic          m_req = 1'b0;
   logic          m_buf = 1'b0;
   logic [3:0]    m_buf_id = 4'd0;
   logic          exp_hit;
   logic [1:0]    exp_phase;

   always #5 clk = ~clk;

   attack_sequencer #(
      .STARTUP_FRAMES (S),
      .ACTIVE_FRAMES  (A),
      .RECOVERY_FRAMES(R),
      .FRAME_W        (FW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_tick     (frame_tick),
      .attack_active  (attack_active),
      .anim_ID_in     (anim_ID_in),
      .hit_stun_active(hit_stun_active),
      .atk_busy       (atk_busy),
      .phase          (phase),
      .hitbox_en      (hitbox_en),
      .anim_ID_out    (anim_ID_out),
      .anim_frame     (anim_frame),
      .atk_done       (atk_done)
   );

   function automatic int m_phase();
      if (!m_busy) return 0;
      if (m_t < S) return 1;
      if (m_t < S + A) return 2;
      return 3;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_t = 0; m_id = 4'd0; m_frame = '0;
         m_done = 1'b0; m_req = 1'b0; m_buf = 1'b0; m_buf_id = 4'd0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (attack_active && !m_req && !hit_stun_active) begin
               m_busy = 1'b1; m_t = 0; m_id = anim_ID_in; m_frame = '0;
            end
         end else if (hit_stun_active) begin
            m_busy = 1'b0; m_t = 0; m_id = 4'd0; m_frame = '0; m_buf = 1'b0;
         end else begin
`ifdef ATK_BUFFER_EN
            if (m_phase() == 3 && attack_active && !m_req && !m_buf) begin
               m_buf = 1'b1; m_buf_id = anim_ID_in;
            end
`endif
            if (frame_tick) begin
               m_t = m_t + 1;
               if (m_frame != '1) m_frame = m_frame + 1'b1;
               if (m_t == TOTAL) begin
                  m_done = 1'b1;
                  if (m_buf) begin
                     m_t = 0; m_frame = '0; m_id = m_buf_id; m_buf = 1'b0;
                  end else begin
                     m_busy = 1'b0;
                  end
               end
            end
         end
         m_req = attack_active;
      end
   end

   always @(negedge clk) begin
      exp_phase = 2'(m_phase());
      exp_hit   = (exp_phase == 2'd2) && !hit_stun_active;
      tests++;
      if (atk_busy !== m_busy || phase !== exp_phase || hitbox_en !== exp_hit ||
          anim_ID_out !== m_id || anim_frame !== m_frame || atk_done !== m_done) begin
         fails++;
         $display("FAIL cycle_check cyc=%0d got busy=%0b phase=%0d hit=%0b id=%0d frame=%0d done=%0b expected busy=%0b phase=%0d hit=%0b id=%0d frame=%0d done=%0b",
                  cyc, atk_busy, phase, hitbox_en, anim_ID_out, anim_frame, atk_done,
                  m_busy, exp_phase, exp_hit, m_id, m_frame, m_done);
      end
      if (atk_done === 1'b1) done_cnt++;
      if (hitbox_en === 1'b1) hit_cnt++;
   end

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         cyc++;
         frame_tick = tick_en && (cyc % 4 == 0);
      end
   endtask

   task automatic wait_phase(input logic [1:0] p, input string name);
      int k = 0;
      while (phase !== p && k < 100) begin
         step();
         k++;
      end
      check(name, int'(phase), int'(p));
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (atk_done !== 1'b1 && k < 100) begin
         step();
         k++;
      end
      check(name, int'(atk_done), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      step(3);
      check("reset_busy", atk_busy, 0);
      check("reset_phase", phase, 0);
      check("reset_hitbox", hitbox_en, 0);
      check("reset_id", anim_ID_out, 0);
      check("reset_frame", anim_frame, 0);
      check("reset_done", atk_done, 0);
      rst_n = 1'b1;
      tick_en = 1'b1;
      step(2);

      // Basic timing with a held button; later ID changes must not leak in.
      attack_active = 1'b1;
      anim_ID_in = 4'd6;
      step();
      anim_ID_in = 4'd2;
      wait_done("basic_done");
      check("basic_phase_at_done", phase, 0);
      check("basic_id", anim_ID_out, 6);
      check("basic_frame", anim_frame, 13);
      step();
      check("basic_done_single", atk_done, 0);
      check("basic_done_count", done_cnt, 1);
      check("basic_hitbox_cycles", hit_cnt, 16);

      // Held button must not retrigger; release and re-press starts anew.
      step(30);
      check("held_no_retrigger", atk_busy, 0);
      check("held_frame_holds", anim_frame, 13);
      attack_active = 1'b0;
      step(2);
      attack_active = 1'b1;
      anim_ID_in = 4'd3;
      step();
      check("repress_busy", atk_busy, 1);
      check("repress_id", anim_ID_out, 3);

      // Stun during ACTIVE: hitbox drops at once, abort on next edge.
      wait_phase(2'd2, "reach_active");
      step(5);
      check("stun_pre_phase", phase, 2);
      hit_stun_active = 1'b1;
      #1;
      check("stun_hitbox_comb", hitbox_en, 0);
      check("stun_phase_same_cycle", phase, 2);
      step();
      check("stun_phase", phase, 0);
      check("stun_frame", anim_frame, 0);
      check("stun_id", anim_ID_out, 0);
      step(3);
      hit_stun_active = 1'b0;
      check("stun_no_done", done_cnt, 1);

      // Press while stunned in IDLE is blocked; the still-held button later does nothing.
      attack_active = 1'b0;
      hit_stun_active = 1'b1;
      step(2);
      attack_active = 1'b1;
      anim_ID_in = 4'd5;
      step(3);
      check("blocked_busy", atk_busy, 0);
      hit_stun_active = 1'b0;
      step(3);
      check("blocked_held_busy", atk_busy, 0);
      attack_active = 1'b0;
      step(2);

      // A tick coincident with the start cycle is ignored.
      tick_en = 1'b0;
      step();
      attack_active = 1'b1;
      anim_ID_in = 4'd9;
      frame_tick = 1'b1;
      step();
      check("coinc_phase", phase, 1);
      check("coinc_frame", anim_frame, 0);
      check("coinc_id", anim_ID_out, 9);
      frame_tick = 1'b1;
      step();
      check("first_tick_frame", anim_frame, 1);
      tick_en = 1'b1;
      attack_active = 1'b0;

      // Reset mid-RECOVERY clears everything asynchronously, no completion afterwards.
      wait_phase(2'd3, "reach_recovery");
      step(2);
      rst_n = 1'b0;
      #1;
      check("rst_busy", atk_busy, 0);
      check("rst_phase", phase, 0);
      check("rst_id", anim_ID_out, 0);
      check("rst_frame", anim_frame, 0);
      check("rst_done", atk_done, 0);
      step();
      rst_n = 1'b1;
      step(60);
      check("rst_no_done", done_cnt, 1);
      check("rst_idle", atk_busy, 0);

      // Re-press during RECOVERY.
      attack_active = 1'b1;
      anim_ID_in = 4'd4;
      step();
      attack_active = 1'b0;
      wait_phase(2'd3, "buf_reach_recovery");
      step(2);
      attack_active = 1'b1;
      anim_ID_in = 4'd7;
      step();
      anim_ID_in = 4'd1;
      wait_done("buf_first_done");
`ifdef ATK_BUFFER_EN
      check("buf_chain_phase", phase, 1);
      check("buf_chain_id", anim_ID_out, 7);
      check("buf_chain_frame", anim_frame, 0);
      step();
      wait_done("buf_second_done");
      check("buf_second_phase", phase, 0);
      check("buf_second_id", anim_ID_out, 7);
`else
      check("nobuf_phase", phase, 0);
      check("nobuf_id", anim_ID_out, 4);
      step(40);
      check("nobuf_idle", atk_busy, 0);
`endif
      attack_active = 1'b0;
      step(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
